// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the combination lock: state encoding and
// the 2-bit symbol alphabet sampled from {X1,X0}.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_C    = 3'd1,
    S_CB   = 3'd2,
    S_CBB  = 3'd3,
    S_CBBA = 3'd4,
    S_OPEN = 3'd5
  } state_t;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_A    = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_C    = 2'b11;

  // A wrong C re-enters the sequence at S_C; any other wrong symbol drops to S_IDLE.
  function automatic state_t restart_state(input logic [1:0] sym);
    return (sym == SYM_C) ? S_C : S_IDLE;
  endfunction

endpackage

// File: rtl/combo_lock_if.sv
// Symbol/indicator bundle for the combination lock. The driver side owns the
// symbol bits, the lock side owns the led.
interface combo_lock_if;
  logic X0;
  logic X1;
  logic led;

  modport master (output X0, output X1, input led);
  modport slave  (input X0, input X1, output led);
endinterface

// File: rtl/combo_lock_fsm.sv
// Sequential combination lock. Consumes one symbol {X1,X0} per clock and
// latches led once the sequence C,B,B,A,A has been seen on consecutive
// non-idle samples. Only reset clears the unlocked state.
module combo_lock_fsm
  import combo_lock_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic X0,
  input  logic X1,
  output logic led
);

  logic [1:0] sym;
  state_t     state_q;
  state_t     state_d;

  assign sym = {X1, X0};

  // Next-state decode; idle symbols hold, illegal encodings recover to S_IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sym != SYM_NONE) state_d = restart_state(sym);
      end
      S_C: begin
        if (sym == SYM_B)         state_d = S_CB;
        else if (sym != SYM_NONE) state_d = restart_state(sym);
      end
      S_CB: begin
        if (sym == SYM_B)         state_d = S_CBB;
        else if (sym != SYM_NONE) state_d = restart_state(sym);
      end
      S_CBB: begin
        if (sym == SYM_A)         state_d = S_CBBA;
        else if (sym != SYM_NONE) state_d = restart_state(sym);
      end
      S_CBBA: begin
        if (sym == SYM_A)         state_d = S_OPEN;
        else if (sym != SYM_NONE) state_d = restart_state(sym);
      end
      S_OPEN:  state_d = S_OPEN;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset takes priority over any symbol.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // led comes straight from the state register, so no input-to-output path exists.
  assign led = (state_q == S_OPEN);

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Scoreboard bench for combo_lock_fsm: each driven symbol pushes the led value
// an independent progress-counter model predicts, popped and compared after the edge.
module tb_combo_lock_fsm;

  logic clk = 1'b0;
  logic reset;
  int   nerr = 0;
  int   nchk = 0;
  int   prog = 0;
  bit   exp_q[$];
  logic [1:0] code [5];
  logic [1:0] seq [$];

  always #5 clk = ~clk;

  combo_lock_if lif ();

  combo_lock_fsm dut (
    .clk   (clk),
    .reset (reset),
    .X0    (lif.X0),
    .X1    (lif.X1),
    .led   (lif.led)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: count how far into the code we are; C restarts at 1, others at 0.
  task automatic model(input logic [1:0] sym, input logic rst);
    if (rst)                  prog = 0;
    else if (prog == 5)       prog = 5;
    else if (sym == 2'b00)    prog = prog;
    else if (sym == code[prog]) prog = prog + 1;
    else if (sym == 2'b11)    prog = 1;
    else                      prog = 0;
  endtask

  task automatic step(input logic [1:0] sym, input logic rst, input string tag);
    @(negedge clk);
    lif.X1 = sym[1];
    lif.X0 = sym[0];
    reset  = rst;
    model(sym, rst);
    exp_q.push_back(prog == 5);
    @(posedge clk);
    #1;
    chk(tag, lif.led, exp_q.pop_front());
  endtask

  task automatic run_seq(input string tag);
    foreach (seq[i]) step(seq[i], 1'b0, tag);
  endtask

  initial begin
    code[0] = 2'b11; code[1] = 2'b10; code[2] = 2'b10; code[3] = 2'b01; code[4] = 2'b01;
    reset  = 1'b1;
    lif.X0 = 1'b0;
    lif.X1 = 1'b0;

    step(2'b00, 1'b1, "reset");
    chk("reset_led0", lif.led, 1'b0);

    seq = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    run_seq("idle");

    seq = '{2'b11, 2'b10, 2'b10, 2'b01};
    run_seq("code_pre");
    chk("latency_before_last_a", lif.led, 1'b0);
    step(2'b01, 1'b0, "code_last");
    chk("unlock", lif.led, 1'b1);

    seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    run_seq("latched");
    chk("still_open", lif.led, 1'b1);
    step(2'b11, 1'b1, "reset_open");
    chk("reset_clears", lif.led, 1'b0);

    seq = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
    run_seq("wrong_third");
    chk("wrong_locked", lif.led, 1'b0);
    seq = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
    run_seq("code_again");
    chk("unlock2", lif.led, 1'b1);
    step(2'b00, 1'b1, "reset2");

    seq = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01};
    run_seq("idles");
    chk("unlock_idles", lif.led, 1'b1);
    step(2'b00, 1'b1, "reset3");

    seq = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
    run_seq("c_restart");
    chk("unlock_restart", lif.led, 1'b1);
    step(2'b00, 1'b1, "reset4");

    seq = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
    run_seq("wrong_b_cbba");
    chk("wrong_b_locked", lif.led, 1'b0);
    step(2'b00, 1'b1, "reset5");

    seq = '{2'b11, 2'b10, 2'b10, 2'b01};
    run_seq("to_cbba");
    step(2'b01, 1'b1, "reset_vs_a");
    chk("reset_priority", lif.led, 1'b0);
    step(2'b01, 1'b0, "after_reset_a");
    chk("no_unlock_after_reset", lif.led, 1'b0);

    for (int k = 0; k < 40; k++) step(2'($urandom_range(0, 3)), 1'b0, "random");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
